// File: rtl/l2_burst_responder_if.sv
// Burst-read bus between the L1 refill FSM and the L2 responder, bundled
// with the word-wide backing-memory read port the responder drives.
//   slave  : responder view (l2_burst_responder)
//   master : requester + backing-memory view (L1 side / memory model)
// Signals:
//   l2_rreq, l2_addr, l2_burst_size : burst request from L1
//   l2_rdata, l2_busy               : streamed data / fetch-in-progress
//   mem_req, mem_addr               : backing-memory read request/address
//   mem_rdata, mem_ack              : backing-memory read data / complete
interface l2_burst_responder_if;
  logic        l2_rreq;
  logic [31:0] l2_addr;
  logic [4:0]  l2_burst_size;
  logic [31:0] l2_rdata;
  logic        l2_busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  l2_rreq, l2_addr, l2_burst_size, mem_rdata, mem_ack,
    output l2_rdata, l2_busy, mem_req, mem_addr
  );

  modport master (
    output l2_rreq, l2_addr, l2_burst_size, mem_rdata, mem_ack,
    input  l2_rdata, l2_busy, mem_req, mem_addr
  );
endinterface

// File: rtl/l2_burst_responder.sv
// L2-side responder for L1 burst reads. Accepts one request, fetches the
// words one at a time from the backing memory into a line buffer while
// l2_busy is high, then streams them back one word per cycle in ascending
// address order (no flow control on the stream).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : l2_burst_responder_if.slave (L1 burst bus + backing-memory port)
module l2_burst_responder #(
  parameter int unsigned MAX_BURST = 16
) (
  input logic                  clk,
  input logic                  reset,
  l2_burst_responder_if.slave  bus
);

  localparam int unsigned IDX_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [4:0]  MAX_LEN = 5'(MAX_BURST);

  // ZLEN holds busy for the single cycle a zero-length request produces.
  typedef enum logic [1:0] {IDLE, ZLEN, FETCH, STREAM} state_t;

  state_t      state;
  logic [4:0]  len;
  logic [4:0]  widx;
  logic [4:0]  ridx;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [4:0]  req_len;
  logic        wr_en;
  logic [31:0] buffer [MAX_BURST];

  always_comb begin
    req_len = (bus.l2_burst_size > MAX_LEN) ? MAX_LEN : bus.l2_burst_size;
  end

  always_comb begin
    wr_en = (state == FETCH) && mem_req && bus.mem_ack;
  end

  // Buffer is kept out of the reset path; contents are don't-care until fetched.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      buffer[widx[IDX_W-1:0]] <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      len      <= '0;
      widx     <= '0;
      ridx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.l2_rreq) begin
            len  <= req_len;
            widx <= '0;
            busy <= 1'b1;
            if (req_len == '0) begin
              state <= ZLEN;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= bus.l2_addr & 32'hFFFF_FFFC;
              state    <= FETCH;
            end
          end
        end
        ZLEN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        FETCH: begin
          if (mem_req && bus.mem_ack) begin
            widx <= widx + 5'd1;
            if (widx == len - 5'd1) begin
              mem_req <= 1'b0;
              busy    <= 1'b0;
              ridx    <= '0;
              state   <= STREAM;
            end else begin
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        STREAM: begin
          ridx <= ridx + 5'd1;
          if (ridx == len - 5'd1) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.l2_busy  = busy;
  assign bus.mem_req  = mem_req;
  assign bus.mem_addr = mem_addr;

  always_comb begin
    bus.l2_rdata = (state == STREAM) ? buffer[ridx[IDX_W-1:0]] : '0;
  end

endmodule

// File: tb/tb_l2_burst_responder.sv
module tb_l2_burst_responder;
  localparam int unsigned MAXB = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l2_burst_responder_if bus();

  l2_burst_responder #(.MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Memory-model state
  logic [31:0] seed = 32'h1234_5678;
  int unsigned lat_fixed = 1;
  bit          lat_rand  = 1'b0;
  int unsigned lat_max   = 1;
  logic [31:0] acked[$];
  int unsigned lat_sum   = 0;
  int unsigned wait_cnt  = 0;
  int unsigned target    = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h1000 && a < 32'h1040) return 32'hA0 + ((a - 32'h1000) >> 2);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  function automatic int unsigned pick();
    return lat_rand ? $urandom_range(lat_max, 1) : lat_fixed;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Backing memory: acks the held request after 'target' cycles (1 = same
  // cycle), logs every acked address, and throws spurious acks when idle.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  end

  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) begin
      wait_cnt++;
      if (wait_cnt >= target) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_word(bus.mem_addr);
        acked.push_back(bus.mem_addr);
        lat_sum += target;
        wait_cnt = 0;
        target   = pick();
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hDEAD_BEEF;
      end
    end else begin
      bus.mem_ack   = 1'($urandom_range(1, 0));
      bus.mem_rdata = $urandom;
      wait_cnt      = 0;
      target        = pick();
    end
  end

  task automatic run_burst(input logic [31:0] addr, input logic [4:0] size,
                           input int unsigned lat, input bit rnd, input int pulse_at);
    int unsigned len;
    logic [31:0] base;
    int unsigned busy_cnt, req_cnt, nz, addr_chg, busy_stream;
    logic [31:0] prev;
    len  = (size > MAXB) ? MAXB : int'(size);
    base = {addr[31:2], 2'b00};
    lat_fixed = lat; lat_rand = rnd; lat_max = lat;
    acked.delete(); lat_sum = 0;
    @(negedge clk);
    bus.l2_rreq = 1'b1; bus.l2_addr = addr; bus.l2_burst_size = size;
    @(negedge clk);
    bus.l2_rreq = 1'b0; bus.l2_addr = $urandom; bus.l2_burst_size = 5'($urandom);
    check("busy_first", {31'd0, bus.l2_busy}, 32'd1);
    busy_cnt = 0; req_cnt = 0; nz = 0; addr_chg = 0;
    prev = bus.mem_addr;
    while (bus.l2_busy === 1'b1 && busy_cnt < 200) begin
      busy_cnt++;
      if (bus.mem_req === 1'b1) req_cnt++;
      if (bus.l2_rdata !== 32'd0) nz++;
      if (bus.mem_addr !== prev) addr_chg++;
      prev = bus.mem_addr;
      @(negedge clk);
    end
    check("busy_cycles", busy_cnt, (len == 0) ? 32'd1 : lat_sum);
    check("mem_req_cycles", req_cnt, (len == 0) ? 32'd0 : lat_sum);
    check("rdata_zero_busy", nz, 32'd0);
    if (len > 0) check("addr_steps", addr_chg, len - 1);
    check("read_count", 32'(acked.size()), len);
    for (int i = 0; i < acked.size() && i < int'(len); i++)
      check("read_addr", acked[i], base + 32'(4 * i));
    busy_stream = 0;
    for (int i = 0; i < int'(len); i++) begin
      check("stream_word", bus.l2_rdata, mem_word(base + 32'(4 * i)));
      if (bus.l2_busy !== 1'b0 || bus.mem_req !== 1'b0) busy_stream++;
      bus.l2_rreq = (i == pulse_at && i < int'(len) - 1);
      bus.l2_addr = 32'h0000_8000;
      bus.l2_burst_size = 5'd4;
      @(negedge clk);
    end
    bus.l2_rreq = 1'b0;
    check("quiet_stream", busy_stream, 32'd0);
    check("idle_rdata", bus.l2_rdata, 32'd0);
    for (int c = 0; c < 2; c++) begin
      check("idle_busy_req", {30'd0, bus.l2_busy, bus.mem_req}, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.l2_rreq = 1'b0; bus.l2_addr = '0; bus.l2_burst_size = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus.l2_busy}, 32'd0);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_rdata", bus.l2_rdata, 32'd0);
    reset = 1'b0;
    seed = $urandom;

    run_burst(32'h1000, 5'd8, 1, 1'b0, -1);
    run_burst(32'h1000, 5'd8, 3, 1'b0, -1);
    run_burst(32'h2003, 5'd1, 1, 1'b0, -1);
    run_burst(32'h4000, 5'd0, 1, 1'b0, -1);
    run_burst(32'h5000, 5'd20, 1, 1'b0, -1);
    run_burst(32'hFFFF_FFF8, 5'd4, 2, 1'b0, -1);

    // Reset in FETCH after three zero-wait acks
    lat_fixed = 1; lat_rand = 1'b0;
    @(negedge clk);
    bus.l2_rreq = 1'b1; bus.l2_addr = 32'h3000; bus.l2_burst_size = 5'd8;
    @(negedge clk);
    bus.l2_rreq = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, bus.l2_busy}, 32'd0);
    check("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("midrst_rdata", bus.l2_rdata, 32'd0);
    reset = 1'b0;
    run_burst(32'h1000, 5'd8, 1, 1'b0, -1);

    // Request pulsed mid-stream must be dropped
    run_burst(32'h1000, 5'd8, 1, 1'b0, 2);

    for (int n = 0; n < 10; n++) begin
      logic [4:0] sz;
      int pa;
      sz = 5'($urandom_range(20, 0));
      pa = (sz > 2) ? int'($urandom_range(1, 0)) : -1;
      run_burst($urandom, sz, $urandom_range(4, 1), 1'b1, pa);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
